// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int              BUS_WIDTH = 32;
    localparam logic [31:0]     RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    // Fetch-stage occupancy; encodings are fixed because other blocks decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // stage empty
        WAIT = 2'd1,   // address issued, data pending
        HOLD = 2'd2,   // data captured, decode stalled
        DROP = 3       // wrong-path data pending, discard on arrival
    } if_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// IF stage register: tracks the single outstanding fetch, buffers the word
// while decode stalls and swallows wrong-path responses after a flush.
module if_fetch_stage #(
    parameter int                        BUS_WIDTH = if_fetch_stage_pkg::BUS_WIDTH,
    parameter logic [BUS_WIDTH-1:0]      RESET_PC  = BUS_WIDTH'(if_fetch_stage_pkg::RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] next_pc,
    input  logic                 rom_req,
    input  logic                 mem_addr_ok,
    input  logic                 mem_ok,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    input  logic                 jump,
    input  logic                 fence_flush,
    input  logic                 allow_in_id,
    output logic                 allow_in_if,
    output logic [BUS_WIDTH-1:0] pc_if,
    output logic                 valid_if_id,
    output logic [BUS_WIDTH-1:0] instr_if_id,
    output logic [BUS_WIDTH-1:0] pc_if_id
);

    import if_fetch_stage_pkg::*;

    localparam logic [BUS_WIDTH-1:0] NOP = BUS_WIDTH'(NOP_INSTR);

    if_state_e            state;
    if_state_e            state_next;
    logic [BUS_WIDTH-1:0] instr_buf;
    logic                 buf_load;
    logic                 flush;
    logic                 ready_go;
    logic                 accept;

    assign flush    = jump | fence_flush;
    assign ready_go = (state == HOLD) | ((state == WAIT) & mem_ok);
    assign accept   = rom_req & mem_addr_ok & allow_in_if;

    assign valid_if_id = ready_go & ~flush;
    assign pc_if_id    = pc_if;

    // Instruction to decode: live ROM word in WAIT, buffered word in HOLD, NOP otherwise.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        instr_if_id = NOP;
        if (valid_if_id) begin
            instr_if_id = (state == HOLD) ? instr_buf : mem_rdata;
        end
    end

    // IF can take a new address once its current contents are leaving or dead.
    always_comb begin
        allow_in_if = 1'b0;
        unique case (state)
            IDLE:    allow_in_if = 1'b1;
            WAIT:    allow_in_if = mem_ok & (allow_in_id | flush);
            HOLD:    allow_in_if = allow_in_id | flush;
            DROP:    allow_in_if = mem_ok;
            default: allow_in_if = 1'b0;
        endcase
    end

    // Next-state logic; a new accept always wins over flush-driven moves.
    always_comb begin
        state_next = state;
        buf_load   = 1'b0;
        unique case (state)
            IDLE: ;  // flush and stray mem_ok have nothing to act on
            WAIT: begin
                if (mem_ok) begin
                    if (allow_in_id | flush) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                        buf_load   = 1'b1;
                    end
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (allow_in_id | flush) state_next = IDLE;
            end
            DROP: begin
                if (mem_ok) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (accept) state_next = WAIT;
    end

    // State, fetch-address and instruction-buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state     <= IDLE;
            pc_if     <= RESET_PC - BUS_WIDTH'(4);
            // NOTE: the buffer is reset to NOP so a spurious HOLD can never expose stale data.
            instr_buf <= NOP;
        end else begin
            state <= state_next;
            if (accept)   pc_if     <= next_pc;
            if (buf_load) instr_buf <= mem_rdata;
        end
    end

endmodule
